// File: rtl/modport_cfg_bridge.sv
// Per-channel cfg AVMM bridge: serves a small local register file and forwards
// all other in-channel offsets to the adapter config port.
module modport_cfg_bridge #(
  parameter int unsigned CHNL_W      = 6,
  parameter logic [10:0] LOCAL_LIMIT = 11'h200,
  parameter logic [31:0] VERSION     = 32'h0001_0000
) (
  input  logic               i_cfg_avmm_clk,
  input  logic               i_cfg_avmm_rst_n,
  input  logic [CHNL_W-1:0]  i_channel_id,
  input  logic [CHNL_W+10:0] i_cfg_avmm_addr,
  input  logic [3:0]         i_cfg_avmm_byte_en,
  input  logic               i_cfg_avmm_read,
  input  logic               i_cfg_avmm_write,
  input  logic [31:0]        i_cfg_avmm_wdata,
  output logic [31:0]        o_cfg_avmm_rdata,
  output logic               o_cfg_avmm_rdatavld,
  output logic               o_cfg_avmm_waitreq,
  output logic               o_adpt_cfg_read,
  output logic               o_adpt_cfg_write,
  output logic [10:0]        o_adpt_cfg_addr,
  output logic [3:0]         o_adpt_cfg_byte_en,
  output logic [31:0]        o_adpt_cfg_wdata,
  input  logic [31:0]        i_adpt_cfg_rdata,
  input  logic               i_adpt_cfg_rdatavld,
  input  logic               i_adpt_cfg_waitreq,
  output logic               o_dcc_en,
  output logic [7:0]         o_dcc_code,
  input  logic               i_dcc_lock
);
  localparam int unsigned OFF_W  = 11;
  localparam int unsigned WORD_W = OFF_W - 2;

  typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [31:0]       scratch_q;
  logic              dcc_en_q;
  logic [7:0]        dcc_code_q;
  logic              sticky_q;
  logic              lock_q;
  logic              pending_q;
  logic [31:0]       rdata_q;
  logic              rdatavld_q;

  logic [OFF_W-1:0]  offset;
  logic [WORD_W-1:0] word;
  logic              hit, is_local, remote, req, rd_only, remote_req;
  logic              ack, local_wr, lock_fall, status_clr;
  logic [31:0]       local_rdata;

  // Address decode
  assign offset     = i_cfg_avmm_addr[OFF_W-1:0];
  assign word       = offset[OFF_W-1:2];
  assign hit        = (i_cfg_avmm_addr[CHNL_W+OFF_W-1:OFF_W] == i_channel_id);
  assign is_local   = hit && (offset < LOCAL_LIMIT);
  assign remote     = hit && !is_local;
  assign req        = i_cfg_avmm_read || i_cfg_avmm_write;
  assign rd_only    = i_cfg_avmm_read && !i_cfg_avmm_write;
  assign remote_req = remote && req;

  // Remote path passes straight through, gated so misses never reach the adapter
  assign o_adpt_cfg_read    = remote && rd_only;
  assign o_adpt_cfg_write   = remote && i_cfg_avmm_write;
  assign o_adpt_cfg_addr    = remote ? offset : '0;
  assign o_adpt_cfg_byte_en = remote ? i_cfg_avmm_byte_en : '0;
  assign o_adpt_cfg_wdata   = remote ? i_cfg_avmm_wdata : '0;

  assign ack        = (state_q == S_ACK) && req && !remote;
  assign local_wr   = ack && i_cfg_avmm_write && is_local;
  assign lock_fall  = lock_q && !i_dcc_lock && dcc_en_q;
  assign status_clr = local_wr && (word == WORD_W'(3)) && i_cfg_avmm_byte_en[0] && i_cfg_avmm_wdata[1];

  always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
    if (!i_cfg_avmm_rst_n) state_q <= S_IDLE;
    else                   state_q <= state_d;
  end

  // Local/miss handshake; held off while a remote read is still outstanding
  always_comb begin
    state_d            = state_q;
    o_cfg_avmm_waitreq = 1'b1;
    case (state_q)
      S_IDLE: if (req && !remote && !pending_q) state_d = S_ACK;
      S_ACK: begin
        state_d            = S_IDLE;
        o_cfg_avmm_waitreq = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (remote_req) o_cfg_avmm_waitreq = i_adpt_cfg_waitreq;
  end

  always_comb begin
    local_rdata = '0;
    if (is_local) begin
      case (word)
        WORD_W'(0): local_rdata = VERSION;
        WORD_W'(1): local_rdata = scratch_q;
        WORD_W'(2): local_rdata = {16'h0, dcc_code_q, 7'h0, dcc_en_q};
        WORD_W'(3): local_rdata = {30'h0, sticky_q, i_dcc_lock};
        default:    local_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
    if (!i_cfg_avmm_rst_n) begin
      scratch_q  <= '0;
      dcc_en_q   <= 1'b0;
      dcc_code_q <= '0;
      sticky_q   <= 1'b0;
      lock_q     <= 1'b0;
      pending_q  <= 1'b0;
      rdata_q    <= '0;
      rdatavld_q <= 1'b0;
    end else begin
      lock_q <= i_dcc_lock;
      for (int b = 0; b < 4; b++) begin
        if (local_wr && (word == WORD_W'(1)) && i_cfg_avmm_byte_en[b])
          scratch_q[8*b +: 8] <= i_cfg_avmm_wdata[8*b +: 8];
      end
      if (local_wr && (word == WORD_W'(2))) begin
        if (i_cfg_avmm_byte_en[0]) dcc_en_q   <= i_cfg_avmm_wdata[0];
        if (i_cfg_avmm_byte_en[1]) dcc_code_q <= i_cfg_avmm_wdata[15:8];
      end
      // A lock loss in the same cycle as the clear wins
      if (lock_fall)       sticky_q <= 1'b1;
      else if (status_clr) sticky_q <= 1'b0;
      if (i_adpt_cfg_rdatavld) pending_q <= 1'b0;
      if (remote && rd_only && !i_adpt_cfg_waitreq) pending_q <= 1'b1;
      rdatavld_q <= 1'b0;
      if (i_adpt_cfg_rdatavld) begin
        rdatavld_q <= 1'b1;
        rdata_q    <= i_adpt_cfg_rdata;
      end else if (ack && rd_only) begin
        rdatavld_q <= 1'b1;
        rdata_q    <= local_rdata;
      end
    end
  end

  assign o_cfg_avmm_rdata    = rdata_q;
  assign o_cfg_avmm_rdatavld = rdatavld_q;
  assign o_dcc_en            = dcc_en_q;
  assign o_dcc_code          = dcc_code_q;

endmodule

// File: tb/tb_modport_cfg_bridge.sv
// Bench for modport_cfg_bridge: directed steps then randomized host traffic
// against a register-level model and a simple adapter responder.
module tb_modport_cfg_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  channel_id;
  logic [16:0] cfg_addr;
  logic [3:0]  cfg_be;
  logic        cfg_read, cfg_write;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        cfg_rdatavld, cfg_waitreq;
  logic        adpt_read, adpt_write;
  logic [10:0] adpt_addr;
  logic [3:0]  adpt_be;
  logic [31:0] adpt_wdata;
  logic [31:0] adpt_rdata;
  logic        adpt_rdatavld, adpt_waitreq;
  logic        dcc_en;
  logic [7:0]  dcc_code;
  logic        dcc_lock;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  modport_cfg_bridge dut (
    .i_cfg_avmm_clk      (clk),
    .i_cfg_avmm_rst_n    (rst_n),
    .i_channel_id        (channel_id),
    .i_cfg_avmm_addr     (cfg_addr),
    .i_cfg_avmm_byte_en  (cfg_be),
    .i_cfg_avmm_read     (cfg_read),
    .i_cfg_avmm_write    (cfg_write),
    .i_cfg_avmm_wdata    (cfg_wdata),
    .o_cfg_avmm_rdata    (cfg_rdata),
    .o_cfg_avmm_rdatavld (cfg_rdatavld),
    .o_cfg_avmm_waitreq  (cfg_waitreq),
    .o_adpt_cfg_read     (adpt_read),
    .o_adpt_cfg_write    (adpt_write),
    .o_adpt_cfg_addr     (adpt_addr),
    .o_adpt_cfg_byte_en  (adpt_be),
    .o_adpt_cfg_wdata    (adpt_wdata),
    .i_adpt_cfg_rdata    (adpt_rdata),
    .i_adpt_cfg_rdatavld (adpt_rdatavld),
    .i_adpt_cfg_waitreq  (adpt_waitreq),
    .o_dcc_en            (dcc_en),
    .o_dcc_code          (dcc_code),
    .i_dcc_lock          (dcc_lock)
  );

  // Adapter responder: stalls adpt_wait cycles, returns data adpt_lat cycles after accept
  int          adpt_wait = 0;
  int          adpt_lat  = 0;
  logic [31:0] adpt_data = 32'h0;
  int          stub_cnt  = 0;
  int          rv_cnt    = 0;
  int          adpt_seen = 0;
  logic [31:0] pend_data = 32'h0;
  logic [10:0] cap_addr  = 11'h0;
  logic [3:0]  cap_be    = 4'h0;
  logic [31:0] cap_wdata = 32'h0;
  logic        cap_wr    = 1'b0;

  initial begin
    adpt_waitreq  = 1'b1;
    adpt_rdatavld = 1'b0;
    adpt_rdata    = 32'h0;
    forever begin
      @(negedge clk);
      adpt_rdatavld = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          adpt_rdatavld = 1'b1;
          adpt_rdata    = pend_data;
        end
      end
      if (adpt_read || adpt_write) begin
        adpt_seen++;
        if (stub_cnt < adpt_wait) begin
          adpt_waitreq = 1'b1;
          stub_cnt++;
        end else begin
          adpt_waitreq = 1'b0;
          stub_cnt     = 0;
          cap_addr     = adpt_addr;
          cap_be       = adpt_be;
          cap_wdata    = adpt_wdata;
          cap_wr       = adpt_write;
          if (adpt_read) begin
            rv_cnt    = adpt_lat + 1;
            pend_data = adpt_data;
          end
        end
      end else begin
        adpt_waitreq = 1'b1;
        stub_cnt     = 0;
      end
    end
  end

  // Register model
  logic [31:0] m_scratch;
  logic        m_en;
  logic [7:0]  m_code;
  logic        m_sticky;

  task automatic model_reset();
    m_scratch = 32'h0;
    m_en      = 1'b0;
    m_code    = 8'h0;
    m_sticky  = 1'b0;
  endtask

  function automatic logic [31:0] exp_local(input logic [10:0] off);
    int w;
    w = int'(off) / 4;
    if (w == 0) return 32'h0001_0000;
    if (w == 1) return m_scratch;
    if (w == 2) return {16'h0, m_code, 7'h0, m_en};
    if (w == 3) return {30'h0, m_sticky, dcc_lock};
    return 32'h0;
  endfunction

  task automatic model_write(input logic [10:0] off, input logic [3:0] be, input logic [31:0] wd);
    int w;
    w = int'(off) / 4;
    if (w == 1) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_scratch[8*b +: 8] = wd[8*b +: 8];
    end else if (w == 2) begin
      if (be[0]) m_en = wd[0];
      if (be[1]) m_code = wd[15:8];
    end else if (w == 3) begin
      if (be[0] && wd[1]) m_sticky = 1'b0;
    end
  endtask

  task automatic set_lock(input logic v);
    if (m_en && dcc_lock && !v) m_sticky = 1'b1;
    dcc_lock = v;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One host access; starts and ends one time unit after a rising edge
  task automatic host_access(input logic rd, input logic wr, input logic [16:0] addr,
                             input logic [3:0] be, input logic [31:0] wd,
                             output logic [31:0] rdata, output logic vld,
                             output int waits, output int lat);
    int limit;
    cfg_addr  = addr;
    cfg_be    = be;
    cfg_wdata = wd;
    cfg_read  = rd;
    cfg_write = wr;
    waits = 0;
    rdata = 32'h0;
    vld   = 1'b0;
    lat   = -1;
    forever begin
      @(negedge clk); #1;
      if (!cfg_waitreq) break;
      waits++;
      if (waits > 40) begin
        total++;
        bad++;
        $error("FAIL accept_timeout: waitreq still high after %0d cycles, required low", waits);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cfg_read  = 1'b0;
    cfg_write = 1'b0;
    limit = (rd && !wr) ? 30 : 3;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk); #1;
      if (cfg_rdatavld) begin
        vld   = 1'b1;
        rdata = cfg_rdata;
        lat   = n;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [16:0] la(input logic [5:0] ch, input logic [10:0] off);
    return {ch, off};
  endfunction

  initial begin
    logic [31:0] rdata;
    logic        vld;
    int          waits, lat, w, op, seen0;
    logic [10:0] off;
    logic [5:0]  ch;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        both;

    rst_n = 1'b0;
    channel_id = 6'h05;
    cfg_addr = '0; cfg_be = '0; cfg_read = 1'b0; cfg_write = 1'b0; cfg_wdata = '0;
    dcc_lock = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_waitreq", 32'(cfg_waitreq), 32'h1);
    chk("rst_rdatavld", 32'(cfg_rdatavld), 32'h0);
    chk("rst_rdata", cfg_rdata, 32'h0);
    chk("rst_dcc", {23'h0, dcc_en, dcc_code}, 32'h0);
    chk("rst_adpt", {30'h0, adpt_read, adpt_write}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ID read
    host_access(1'b1, 1'b0, 17'h02800, 4'hF, 32'h0, rdata, vld, waits, lat);
    chk("id_waits", 32'(waits), 32'd1);
    chk("id_vld", 32'(vld), 32'h1);
    chk("id_lat", 32'(lat), 32'd0);
    chk("id_data", rdata, 32'h0001_0000);

    // Partial-byte scratch write
    host_access(1'b0, 1'b1, la(6'h05, 11'h004), 4'b0101, 32'hA5A5_5A5A, rdata, vld, waits, lat);
    model_write(11'h004, 4'b0101, 32'hA5A5_5A5A);
    chk("scr_wr_vld", 32'(vld), 32'h0);
    host_access(1'b1, 1'b0, la(6'h05, 11'h004), 4'hF, 32'h0, rdata, vld, waits, lat);
    chk("scr_rd", rdata, 32'h00A5_005A);

    // DCC control and sticky lock-lost
    host_access(1'b0, 1'b1, la(6'h05, 11'h008), 4'hF, 32'h0000_3701, rdata, vld, waits, lat);
    model_write(11'h008, 4'hF, 32'h0000_3701);
    chk("dcc_en", 32'(dcc_en), 32'h1);
    chk("dcc_code", 32'(dcc_code), 32'h37);
    set_lock(1'b1);
    set_lock(1'b0);
    host_access(1'b1, 1'b0, la(6'h05, 11'h00C), 4'hF, 32'h0, rdata, vld, waits, lat);
    chk("status_lost", rdata, 32'h2);
    host_access(1'b0, 1'b1, la(6'h05, 11'h00C), 4'hF, 32'h2, rdata, vld, waits, lat);
    model_write(11'h00C, 4'hF, 32'h2);
    host_access(1'b1, 1'b0, la(6'h05, 11'h00C), 4'hF, 32'h0, rdata, vld, waits, lat);
    chk("status_clr", rdata, 32'h0);

    // Remote read with a 3-cycle adapter stall
    adpt_wait = 3; adpt_lat = 0; adpt_data = 32'hDEAD_BEEF;
    host_access(1'b1, 1'b0, la(6'h05, 11'h400), 4'hF, 32'h0, rdata, vld, waits, lat);
    chk("rem_waits", 32'(waits), 32'd3);
    chk("rem_addr", 32'(cap_addr), 32'h400);
    chk("rem_lat", 32'(lat), 32'd1);
    chk("rem_data", rdata, 32'hDEAD_BEEF);

    // Channel miss
    seen0 = adpt_seen;
    host_access(1'b1, 1'b0, la(6'h06, 11'h400), 4'hF, 32'h0, rdata, vld, waits, lat);
    chk("miss_no_adpt", 32'(adpt_seen - seen0), 32'd0);
    chk("miss_vld", 32'(vld), 32'h1);
    chk("miss_data", rdata, 32'h0);
    chk("miss_waits", 32'(waits), 32'd1);

    // Reset while a local write sits in its ACK cycle
    cfg_addr = la(6'h05, 11'h004); cfg_be = 4'hF; cfg_wdata = 32'h1234_5678;
    cfg_write = 1'b1;
    @(posedge clk); #1;
    chk("ack_waitreq", 32'(cfg_waitreq), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("abort_waitreq", 32'(cfg_waitreq), 32'h1);
    cfg_write = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("abort_vld", 32'(cfg_rdatavld), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_vld2", 32'(cfg_rdatavld), 32'h0);
    chk("abort_dcc_en", 32'(dcc_en), 32'h0);
    host_access(1'b1, 1'b0, la(6'h05, 11'h004), 4'hF, 32'h0, rdata, vld, waits, lat);
    chk("abort_scratch", rdata, 32'h0);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          w = $urandom_range(0, 3) == 0 ? $urandom_range(4, 127) : $urandom_range(0, 3);
          off  = 11'(w * 4 + $urandom_range(0, 3));
          be   = 4'($urandom_range(0, 15));
          wd   = $urandom;
          both = ($urandom_range(0, 4) == 0);
          host_access(both, 1'b1, la(6'h05, off), be, wd, rdata, vld, waits, lat);
          model_write(off, be, wd);
          chk("r_lwr_vld", 32'(vld), 32'h0);
          chk("r_lwr_waits", 32'(waits), 32'd1);
          chk("r_lwr_dcc", {23'h0, dcc_en, dcc_code}, {23'h0, m_en, m_code});
        end
        1: begin
          w   = $urandom_range(0, 3) == 0 ? $urandom_range(4, 127) : $urandom_range(0, 3);
          off = 11'(w * 4 + $urandom_range(0, 3));
          host_access(1'b1, 1'b0, la(6'h05, off), 4'hF, 32'h0, rdata, vld, waits, lat);
          chk("r_lrd_vld", 32'(vld), 32'h1);
          chk("r_lrd_lat", 32'(lat), 32'd0);
          chk("r_lrd_data", rdata, exp_local(off));
        end
        2: set_lock(1'($urandom_range(0, 1)));
        3: begin
          off = 11'(11'h200 + 4 * $urandom_range(0, 383));
          adpt_wait = $urandom_range(0, 3);
          adpt_lat  = $urandom_range(0, 3);
          adpt_data = $urandom;
          host_access(1'b1, 1'b0, la(6'h05, off), 4'hF, 32'h0, rdata, vld, waits, lat);
          chk("r_rrd_waits", 32'(waits), 32'(adpt_wait));
          chk("r_rrd_addr", 32'(cap_addr), 32'(off));
          chk("r_rrd_lat", 32'(lat), 32'(adpt_lat + 1));
          chk("r_rrd_data", rdata, adpt_data);
        end
        4: begin
          off  = 11'(11'h200 + 4 * $urandom_range(0, 383));
          be   = 4'($urandom_range(0, 15));
          wd   = $urandom;
          both = ($urandom_range(0, 3) == 0);
          adpt_wait = $urandom_range(0, 3);
          host_access(both, 1'b1, la(6'h05, off), be, wd, rdata, vld, waits, lat);
          chk("r_rwr_waits", 32'(waits), 32'(adpt_wait));
          chk("r_rwr_fwd", {16'h0, cap_wr, cap_be, cap_addr}, {16'h0, 1'b1, be, off});
          chk("r_rwr_wdata", cap_wdata, wd);
          chk("r_rwr_vld", 32'(vld), 32'h0);
        end
        default: begin
          ch = 6'($urandom_range(0, 63));
          if (ch == 6'h05) ch = 6'h06;
          off   = 11'($urandom_range(0, 2047));
          both  = 1'($urandom_range(0, 1));
          seen0 = adpt_seen;
          host_access(1'b1, both, la(ch, off), 4'hF, $urandom, rdata, vld, waits, lat);
          chk("r_miss_adpt", 32'(adpt_seen - seen0), 32'd0);
          chk("r_miss_vld", 32'(vld), 32'(!both));
          chk("r_miss_data", rdata, 32'h0);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
